keccak_rc_gen: RTL



---
 rtl/keccak_rc_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/keccak_rc_gen.sv
// Keccak-p round-constant generator: the iota LFSR unrolled to yield
// ROUNDS_PER_CYCLE truncated constants per step, with round/last/done tracking.
module keccak_rc_gen #(
  parameter int LANE_WIDTH       = 64,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 start_i,
  input  logic                                 next_i,
  output logic                                 busy_o,
  output logic [4:0]                           round_out_o,
  output logic [ROUNDS_PER_CYCLE*LANE_WIDTH-1:0] const_out_o,
  output logic                                 last_o,
  output logic                                 done_o
);

  localparam int L        = $clog2(LANE_WIDTH);
  localparam int N_ROUNDS = 12 + 2 * L;
  localparam int K        = ROUNDS_PER_CYCLE;
  localparam int CW       = K * LANE_WIDTH;
  localparam logic [4:0] K5     = 5'(K);
  localparam logic [4:0] LAST_R = 5'(N_ROUNDS - K);
  localparam bit   LAST_AT_START = (K == N_ROUNDS);

  if (!(LANE_WIDTH == 8 || LANE_WIDTH == 16 || LANE_WIDTH == 32 || LANE_WIDTH == 64))
  begin : g_bad_width
    $error("keccak_rc_gen: LANE_WIDTH must be 8, 16, 32 or 64");
  end
  if (K < 1 || (N_ROUNDS % K) != 0) begin : g_bad_k
    $error("keccak_rc_gen: ROUNDS_PER_CYCLE must divide the round count");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q;
  logic [7:0]     lfsr_q, lfsr_d, seed;
  logic [CW-1:0]  const_q, rc_d;
  logic [4:0]     round_q;
  logic           busy_q, last_q, done_q;
  logic [7:0]     st;
  logic [63:0]    lane;

  // Unroll 7*K LFSR steps; a restart always seeds from the round-0 state.
  always_comb begin
    seed = start_i ? 8'h01 : lfsr_q;
    st   = seed;
    rc_d = '0;
    lane = '0;
    for (int r = 0; r < K; r++) begin
      lane = '0;
      for (int j = 0; j < 7; j++) begin
        lane = lane | (64'(st[0]) << ((1 << j) - 1));
        st   = {st[6:0], 1'b0} ^ (st[7] ? 8'h71 : 8'h00);
      end
      rc_d[r*LANE_WIDTH +: LANE_WIDTH] = lane[LANE_WIDTH-1:0];
    end
    lfsr_d = st;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      round_q <= '0;
      const_q <= '0;
      lfsr_q  <= 8'h01;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        round_q <= '0;
        const_q <= rc_d;
        lfsr_q  <= lfsr_d;
        last_q  <= LAST_AT_START;
      end else if (state_q == RUN && next_i) begin
        if (last_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          last_q  <= 1'b0;
          round_q <= '0;
          const_q <= '0;
          lfsr_q  <= 8'h01;
          done_q  <= 1'b1;
        end else begin
          round_q <= round_q + K5;
          const_q <= rc_d;
          lfsr_q  <= lfsr_d;
          last_q  <= ((round_q + K5) == LAST_R);
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign round_out_o = round_q;
  assign const_out_o = const_q;
  assign last_o      = last_q;
  assign done_o      = done_q;

endmodule
